// File: rtl/csr_pkg.sv
// Shared types, CSR address map and legality helpers for the CSR access controller.
package csr_pkg;

    localparam int unsigned CsrAddrW = 12;

    // Zicsr funct3 encodings; 3'b000 and 3'b100 are not CSR ops.
    typedef enum logic [2:0] {
        OpRw  = 3'b001,
        OpRs  = 3'b010,
        OpRc  = 3'b011,
        OpRwi = 3'b101,
        OpRsi = 3'b110,
        OpRci = 3'b111
    } csr_op_e;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StWait,
        StWrite,
        StResp,
        StTwrite
    } csr_state_e;

    localparam logic [CsrAddrW-1:0] CsrMstatus  = 12'h300;
    localparam logic [CsrAddrW-1:0] CsrMie      = 12'h304;
    localparam logic [CsrAddrW-1:0] CsrMtvec    = 12'h305;
    localparam logic [CsrAddrW-1:0] CsrMepc     = 12'h341;
    localparam logic [CsrAddrW-1:0] CsrMcause   = 12'h342;
    localparam logic [CsrAddrW-1:0] CsrMip      = 12'h344;
    localparam logic [CsrAddrW-1:0] CsrCycle    = 12'hC00;
    localparam logic [CsrAddrW-1:0] CsrInstret  = 12'hC02;
    localparam logic [CsrAddrW-1:0] CsrCycleh   = 12'hC80;
    localparam logic [CsrAddrW-1:0] CsrInstreth = 12'hC82;

    function automatic logic csr_is_implemented(input logic [CsrAddrW-1:0] addr);
        case (addr)
            CsrMstatus, CsrMie, CsrMtvec, CsrMepc, CsrMcause, CsrMip,
            CsrCycle, CsrInstret, CsrCycleh, CsrInstreth: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic csr_is_readonly(input logic [CsrAddrW-1:0] addr);
        return addr[11:10] == 2'b11;
    endfunction

    function automatic logic csr_op_valid(input logic [2:0] op);
        return op[1:0] != 2'b00;
    endfunction

    // Set/clear with a zero source are pure reads and never write.
    function automatic logic csr_op_writes(input logic [2:0] op, input logic src_zero);
        if (op[1:0] == 2'b01) begin
            return 1'b1;
        end else if (op[1:0] == 2'b00) begin
            return 1'b0;
        end
        return !src_zero;
    endfunction

endpackage

// File: rtl/csr_wdata_calc.sv
// Combinational new-value computation for CSR read-modify-write ops.
module csr_wdata_calc
    import csr_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] old_i,
    input  logic [XLEN-1:0] src_i,
    input  logic            src_zero_i,
    output logic [XLEN-1:0] new_o,
    output logic            do_write_o
);

    // Register and immediate forms share the low two funct3 bits.
    always_comb begin
        new_o = '0;
        case (op_i[1:0])
            2'b01:   new_o = src_i;
            2'b10:   new_o = old_i | src_i;
            2'b11:   new_o = old_i & ~src_i;
            default: new_o = '0;
        endcase
        do_write_o = csr_op_writes(op_i, src_zero_i);
    end

endmodule

// File: rtl/csr_access_ctrl.sv
// Sequences Zicsr read-modify-write transactions and trap writes onto CSR storage.
module csr_access_ctrl
    import csr_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned ADDR_W     = 12,
    parameter bit          CHECK_ADDR = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic              req_src_zero,
    input  logic              req_rd_zero,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_illegal,
    input  logic              trap_valid,
    output logic              trap_ready,
    input  logic [ADDR_W-1:0] trap_addr,
    input  logic [XLEN-1:0]   trap_wdata,
    output logic              csr_rd_en,
    output logic [ADDR_W-1:0] csr_rd_addr,
    input  logic [XLEN-1:0]   csr_rd_data,
    output logic              csr_wr_en,
    output logic [ADDR_W-1:0] csr_wr_addr,
    output logic [XLEN-1:0]   csr_wr_data
);

    csr_state_e        state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [XLEN-1:0]   src_q, src_d;
    logic              src_zero_q, src_zero_d;
    logic              illegal_q, illegal_d;
    logic [XLEN-1:0]   old_q, old_d;
    logic [XLEN-1:0]   new_q, new_d;

    logic [XLEN-1:0]   req_src;
    logic              req_legal;
    logic [XLEN-1:0]   calc_new;
    logic              calc_do_write;

    csr_wdata_calc #(
        .XLEN(XLEN)
    ) u_wdata_calc (
        .op_i      (op_q),
        .old_i     (csr_rd_data),
        .src_i     (src_q),
        .src_zero_i(src_zero_q),
        .new_o     (calc_new),
        .do_write_o(calc_do_write)
    );

    // Legality of the incoming request; latched so later states use captured fields only.
    always_comb begin
        req_src   = req_op[2] ? {{(XLEN-5){1'b0}}, req_wdata[4:0]} : req_wdata;
        req_legal = csr_op_valid(req_op)
                    && !(csr_op_writes(req_op, req_src_zero) && csr_is_readonly(req_addr))
                    && !(CHECK_ADDR && !csr_is_implemented(req_addr));
    end

    // Next-state and output decode; trap writes reuse addr_q/new_q as their latch.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        addr_d       = addr_q;
        src_d        = src_q;
        src_zero_d   = src_zero_q;
        illegal_d    = illegal_q;
        old_d        = old_q;
        new_d        = new_q;
        req_ready    = 1'b0;
        trap_ready   = 1'b0;
        resp_valid   = 1'b0;
        resp_rdata   = '0;
        resp_illegal = 1'b0;
        csr_rd_en    = 1'b0;
        csr_rd_addr  = '0;
        csr_wr_en    = 1'b0;
        csr_wr_addr  = '0;
        csr_wr_data  = '0;

        case (state_q)
            StIdle: begin
                // Gate with reset so both readies read 0 while reset is held.
                trap_ready = reset;
                req_ready  = reset && !trap_valid;
                if (trap_valid) begin
                    addr_d  = trap_addr;
                    new_d   = trap_wdata;
                    state_d = StTwrite;
                end else if (req_valid) begin
                    op_d       = req_op;
                    addr_d     = req_addr;
                    src_d      = req_src;
                    src_zero_d = req_src_zero;
                    illegal_d  = !req_legal;
                    old_d      = '0;
                    new_d      = req_src;
                    if (req_legal && req_op[1:0] == 2'b01 && req_rd_zero) begin
                        state_d = StWrite;
                    end else begin
                        state_d = StRead;
                    end
                end
            end
            StTwrite: begin
                csr_wr_en   = 1'b1;
                csr_wr_addr = addr_q;
                csr_wr_data = new_q;
                state_d     = StIdle;
            end
            StRead: begin
                csr_rd_en   = 1'b1;
                csr_rd_addr = addr_q;
                state_d     = StWait;
            end
            StWait: begin
                old_d   = illegal_q ? '0 : csr_rd_data;
                new_d   = calc_new;
                state_d = (!illegal_q && calc_do_write) ? StWrite : StResp;
            end
            StWrite: begin
                csr_wr_en   = 1'b1;
                csr_wr_addr = addr_q;
                csr_wr_data = new_q;
                state_d     = StResp;
            end
            StResp: begin
                resp_valid   = 1'b1;
                resp_rdata   = old_q;
                resp_illegal = illegal_q;
                if (resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and captured-request registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            op_q       <= '0;
            addr_q     <= '0;
            src_q      <= '0;
            src_zero_q <= 1'b0;
            illegal_q  <= 1'b0;
            old_q      <= '0;
            new_q      <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            src_q      <= src_d;
            src_zero_q <= src_zero_d;
            illegal_q  <= illegal_d;
            old_q      <= old_d;
            new_q      <= new_d;
        end
    end

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Self-checking bench for csr_access_ctrl: directed cases plus random requests vs a CSR model.
module tb_csr_access_ctrl;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [11:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_src_zero;
    logic        req_rd_zero;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_illegal;
    logic        trap_valid;
    logic        trap_ready;
    logic [11:0] trap_addr;
    logic [31:0] trap_wdata;
    logic        csr_rd_en;
    logic [11:0] csr_rd_addr;
    logic [31:0] csr_rd_data;
    logic        csr_wr_en;
    logic [11:0] csr_wr_addr;
    logic [31:0] csr_wr_data;

    int total = 0;
    int bad   = 0;

    // Storage emulation (DUT-facing) and the reference contents kept by the model.
    logic [31:0] mem     [0:4095];
    logic [31:0] ref_mem [0:4095];
    logic        pl_en;
    logic [11:0] pl_addr;
    logic [31:0] pl_data;

    logic [11:0] impl_list [10] = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342,
                                    12'h344, 12'hC00, 12'hC02, 12'hC80, 12'hC82};
    logic [11:0] addr_pool [13] = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342,
                                    12'h344, 12'hC00, 12'hC02, 12'hC80, 12'hC82,
                                    12'h7C0, 12'hFC0, 12'h123};
    logic [2:0]  op_pool   [8]  = '{3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111,
                                    3'b000, 3'b100};

    csr_access_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_src_zero(req_src_zero),
        .req_rd_zero (req_rd_zero),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_rdata  (resp_rdata),
        .resp_illegal(resp_illegal),
        .trap_valid  (trap_valid),
        .trap_ready  (trap_ready),
        .trap_addr   (trap_addr),
        .trap_wdata  (trap_wdata),
        .csr_rd_en   (csr_rd_en),
        .csr_rd_addr (csr_rd_addr),
        .csr_rd_data (csr_rd_data),
        .csr_wr_en   (csr_wr_en),
        .csr_wr_addr (csr_wr_addr),
        .csr_wr_data (csr_wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        if (csr_wr_en) mem[csr_wr_addr] <= csr_wr_data;
        if (csr_rd_en) csr_rd_data <= mem[csr_rd_addr];
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit is_impl(input logic [11:0] a);
        foreach (impl_list[i]) if (impl_list[i] == a) return 1'b1;
        return 1'b0;
    endfunction

    task automatic set_mem(input logic [11:0] a, input logic [31:0] v);
        @(negedge clk);
        pl_en = 1'b1;
        pl_addr = a;
        pl_data = v;
        ref_mem[a] = v;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // One CSR instruction, optionally racing a trap write, checked against the model.
    task automatic do_req(input logic [2:0] op, input logic [11:0] addr, input logic [31:0] wdata,
                          input logic rd_zero, input int hold, input logic trap_en,
                          input logic [11:0] t_addr, input logic [31:0] t_data);
        logic [31:0] src, old, nv, exp_rdata, wr_a, wr_d, got_rdata;
        logic        szero, writes, legal, skip, got_ill, both;
        int          exp_rd, exp_wr, exp_resp, rd_cyc, wr_cyc, resp_cyc, rd_cnt, wr_cnt;

        src   = op[2] ? {27'b0, wdata[4:0]} : wdata;
        szero = (src == 32'b0);

        @(negedge clk);
        req_valid    = 1'b1;
        req_op       = op;
        req_addr     = addr;
        req_wdata    = wdata;
        req_src_zero = szero;
        req_rd_zero  = rd_zero;
        if (trap_en) begin
            trap_valid = 1'b1;
            trap_addr  = t_addr;
            trap_wdata = t_data;
            #1;
            chk("trap_ready_idle", 32'(trap_ready), 32'd1);
            chk("req_ready_vs_trap", 32'(req_ready), 32'd0);
            @(posedge clk);
            #1 trap_valid = 1'b0;
            @(negedge clk);
            chk("trap_wr_en", 32'(csr_wr_en), 32'd1);
            chk("trap_wr_addr", 32'(csr_wr_addr), 32'(t_addr));
            chk("trap_wr_data", csr_wr_data, t_data);
            chk("trap_busy_ready", 32'(req_ready), 32'd0);
            ref_mem[t_addr] = t_data;
            @(negedge clk);
        end else begin
            #1;
        end
        chk("req_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;

        // Model: computed from the instruction rules with plain arithmetic.
        writes = (op == 3'b001 || op == 3'b101) || (op[1:0] != 2'b00 && !szero);
        legal  = (op[1:0] != 2'b00) && !(writes && addr[11:10] == 2'b11) && is_impl(addr);
        skip   = legal && op[1:0] == 2'b01 && rd_zero;
        old    = ref_mem[addr];
        case (op[1:0])
            2'b01:   nv = src;
            2'b10:   nv = old | src;
            2'b11:   nv = old & ~src;
            default: nv = 32'b0;
        endcase
        exp_rd    = skip ? 0 : 1;
        exp_wr    = (legal && writes) ? (skip ? 1 : 3) : 0;
        exp_resp  = skip ? 2 : ((exp_wr != 0) ? 4 : 3);
        exp_rdata = (legal && !skip) ? old : 32'b0;

        rd_cyc = 0; wr_cyc = 0; resp_cyc = 0; rd_cnt = 0; wr_cnt = 0; both = 1'b0;
        wr_a = '0; wr_d = '0; got_rdata = '0; got_ill = 1'b0;
        for (int k = 1; k <= 8 && resp_cyc == 0; k++) begin
            @(negedge clk);
            if (csr_rd_en) begin
                rd_cnt++;
                if (rd_cyc == 0) rd_cyc = k;
                chk("rd_addr", 32'(csr_rd_addr), 32'(addr));
            end
            if (csr_wr_en) begin
                wr_cnt++;
                wr_cyc = k;
                wr_a = 32'(csr_wr_addr);
                wr_d = csr_wr_data;
            end
            if (csr_rd_en && csr_wr_en) both = 1'b1;
            if (resp_valid) begin
                resp_cyc  = k;
                got_rdata = resp_rdata;
                got_ill   = resp_illegal;
            end
        end

        chk("resp_latency", 32'(resp_cyc), 32'(exp_resp));
        chk("rd_count", 32'(rd_cnt), 32'(exp_rd));
        chk("rd_cycle", 32'(rd_cyc), 32'(exp_rd));
        chk("wr_count", 32'(wr_cnt), (exp_wr != 0) ? 32'd1 : 32'd0);
        chk("wr_cycle", 32'(wr_cyc), 32'(exp_wr));
        chk("rd_wr_overlap", 32'(both), 32'd0);
        if (exp_wr != 0) begin
            chk("wr_addr", wr_a, 32'(addr));
            chk("wr_data", wr_d, nv);
        end
        chk("resp_rdata", got_rdata, exp_rdata);
        chk("resp_illegal", 32'(got_ill), 32'(!legal));

        if (resp_cyc != 0) begin
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                chk("hold_valid", 32'(resp_valid), 32'd1);
                chk("hold_rdata", resp_rdata, exp_rdata);
                chk("hold_illegal", 32'(resp_illegal), 32'(!legal));
            end
            resp_ready = 1'b1;
            @(posedge clk);
            #1 resp_ready = 1'b0;
            @(negedge clk);
            chk("resp_done", 32'(resp_valid), 32'd0);
        end

        if (legal && writes) ref_mem[addr] = nv;
        chk("storage", mem[addr], ref_mem[addr]);
    endtask

    initial begin
        int wr_seen;
        reset = 1'b0;
        req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0;
        req_src_zero = 1'b0; req_rd_zero = 1'b0; resp_ready = 1'b0;
        trap_valid = 1'b1; trap_addr = 12'h341; trap_wdata = 32'hFFFF_FFFF;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;

        // Reset state: readies and strobes all 0 even with a trap pending.
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_trap_ready", 32'(trap_ready), 32'd0);
        chk("rst_wr_en", 32'(csr_wr_en), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        trap_valid = 1'b0;
        reset = 1'b1;

        foreach (addr_pool[i]) set_mem(addr_pool[i], $urandom);

        // CSRRS read+write.
        set_mem(12'h304, 32'h0000_0008);
        do_req(3'b010, 12'h304, 32'h0000_0080, 1'b0, 0, 1'b0, '0, '0);
        // CSRRCI and a zero-uimm CSRRSI on a read-only counter.
        set_mem(12'h300, 32'h0000_001F);
        do_req(3'b111, 12'h300, 32'h0000_0003, 1'b0, 0, 1'b0, '0, '0);
        set_mem(12'hC00, 32'h0000_ABCD);
        do_req(3'b110, 12'hC00, 32'h0000_0000, 1'b0, 0, 1'b0, '0, '0);
        // Illegal: write to read-only, unimplemented address, reserved op.
        do_req(3'b001, 12'hC02, 32'h0000_0001, 1'b0, 0, 1'b0, '0, '0);
        do_req(3'b001, 12'h7C0, 32'h0000_0005, 1'b1, 0, 1'b0, '0, '0);
        do_req(3'b100, 12'h304, 32'h0000_0001, 1'b0, 0, 1'b0, '0, '0);
        // CSRRW with rd=x0 skips the read.
        do_req(3'b001, 12'h305, 32'h8000_0100, 1'b1, 0, 1'b0, '0, '0);
        // Trap beats request; response held for 3 cycles.
        do_req(3'b010, 12'h304, 32'h0000_0001, 1'b0, 3, 1'b1, 12'h341, 32'h0000_1234);

        // Reset during WAIT drops the transaction.
        set_mem(12'h342, 32'h0000_0055);
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'b010; req_addr = 12'h342; req_wdata = 32'h0000_00F0;
        req_src_zero = 1'b0; req_rd_zero = 1'b0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("rstw_read", 32'(csr_rd_en), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rstw_rd_en", 32'(csr_rd_en), 32'd0);
        chk("rstw_wr_en", 32'(csr_wr_en), 32'd0);
        chk("rstw_resp_valid", 32'(resp_valid), 32'd0);
        chk("rstw_req_ready", 32'(req_ready), 32'd0);
        chk("rstw_trap_ready", 32'(trap_ready), 32'd0);
        chk("rstw_wr_data", csr_wr_data, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        wr_seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (csr_wr_en || resp_valid) wr_seen++;
        end
        chk("rstw_no_write", 32'(wr_seen), 32'd0);
        chk("rstw_storage", mem[12'h342], 32'h0000_0055);
        do_req(3'b010, 12'h342, 32'h0000_00F0, 1'b0, 1, 1'b0, '0, '0);

        // Random requests.
        for (int n = 0; n < 40; n++) begin
            logic [31:0] wd;
            logic        ten;
            wd  = $urandom;
            if ($urandom_range(0, 3) == 0) wd = 32'b0;
            ten = ($urandom_range(0, 5) == 0);
            do_req(op_pool[$urandom_range(0, 7)], addr_pool[$urandom_range(0, 12)], wd,
                   1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), ten,
                   impl_list[$urandom_range(0, 9)], $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/csr_access_ctrl.md
Name: csr_access_ctrl

Overview:
- Sequences Zicsr instructions (CSRRW/S/C and immediate forms) against the CSR storage array as read-modify-write transactions.
- Arbitrates the storage write port between the execute-stage instruction requester and the trap unit (mepc/mcause/mstatus updates).
- Flags illegal CSR accesses.
- Sits between the execute stage and the CSR register file; the storage has one read port with 1-cycle registered read latency and one write port.

Parameters:
XLEN, 32, CSR data width
ADDR_W, 12, CSR address width
CHECK_ADDR, 1, 1 = accesses outside the implemented-address list are illegal

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  1  instruction CSR request valid
req_ready  out  1  request accepted when valid&&ready
req_op  in  3  funct3 (001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI)
req_addr  in  ADDR_W  CSR address
req_wdata  in  XLEN  rs1 value; for immediate ops only [4:0] is used (uimm)
req_src_zero  in  1  rs1==x0 (register ops) or uimm==0 (immediate ops)
req_rd_zero  in  1  rd==x0
resp_valid  out  1  result valid
resp_ready  in  1  result consumed
resp_rdata  out  XLEN  old CSR value for rd
resp_illegal  out  1  illegal-instruction indication
trap_valid  in  1  trap-unit write request
trap_ready  out  1  trap write accepted
trap_addr  in  ADDR_W  trap write address
trap_wdata  in  XLEN  trap write data
csr_rd_en  out  1  storage read strobe
csr_rd_addr  out  ADDR_W  storage read address
csr_rd_data  in  XLEN  storage read data, valid the cycle after csr_rd_en
csr_wr_en  out  1  storage write strobe
csr_wr_addr  out  ADDR_W  storage write address
csr_wr_data  out  XLEN  storage write data

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; captured request cleared.
  - All outputs 0, including req_ready and trap_ready.
  - An in-flight transaction is dropped; no write is issued afterwards.
- States: IDLE, READ, WAIT, WRITE, RESP, TWRITE.
- IDLE:
  - trap_ready=1.
  - req_ready=!trap_valid; trap has fixed priority.
  - trap_valid → latch trap_addr/trap_wdata, go to TWRITE.
  - Otherwise req_valid → capture op/addr/wdata/flags.
  - Next state after capture is WRITE if op is RW/RWI with rd_zero and the op is legal (no read is performed); otherwise READ.
- TWRITE: csr_wr_en=1 with the latched addr/data for 1 cycle, then IDLE. No legality check is applied to trap writes.
- READ: csr_rd_en=1 and csr_rd_addr=addr for 1 cycle, then WAIT.
- WAIT:
  - Capture csr_rd_data into old.
  - Compute new:
    - RW: src
    - RS: old|src
    - RC: old&~src
    - src = req_wdata for register ops; zero-extended uimm for immediate ops.
  - do_write = RW/RWI, or (RS/RC/RSI/RCI and !src_zero).
  - Next state: WRITE if legal && do_write, else RESP.
- WRITE: csr_wr_en=1, csr_wr_addr=addr, csr_wr_data=new for 1 cycle, then RESP.
- RESP:
  - resp_valid=1.
  - resp_rdata = old (0 if the read was skipped).
  - Both fields hold stable until resp_ready; then IDLE.
  - resp_ready high in the same cycle as the first resp_valid completes in 1 cycle.
- Legality, all evaluated on captured fields:
  - op 000 or 100 → illegal.
  - do_write && addr[11:10]==2'b11 (read-only) → illegal.
  - CHECK_ADDR && addr not implemented → illegal.
  - An illegal request never asserts csr_wr_en and returns resp_rdata=0.
  - An illegal access with op legal and rd_zero RW still takes the READ path, so no write occurs.
- Implemented addresses: 0x300, 0x304, 0x305, 0x341, 0x342, 0x344, 0xC00, 0xC02, 0xC80, 0xC82.
- Latency from accept cycle T:
  - read + write: resp_valid at T+4.
  - read only: T+3.
  - RW with rd_zero: T+2.
  - trap write: csr_wr_en at T+1; next accept at T+2.
- Strobes: csr_rd_en and csr_wr_en are never high in the same cycle. At most one request is outstanding.
- All address/data outputs are 0 whenever their strobe is low.

Decomposition:
- csr_pkg holds:
  - op encodings as an enum;
  - the FSM state enum;
  - CSR address constants;
  - function csr_is_implemented(addr);
  - function csr_is_readonly(addr).
- One combinational sub-module, csr_wdata_calc: (op, old, src) → new, do_write.

Test Plan:
1. CSRRS: addr 0x304, old 0x0000_0008, rs1=0x0000_0080, src_zero=0 → csr_rd_en at T+1; csr_wr_en at T+3 with data 0x0000_0088; resp_rdata 0x0000_0008 at T+4.
2. CSRRCI: addr 0x300, old 0x0000_001F, uimm=5'h03 → write 0x0000_001C; CSRRSI with uimm=0 on addr 0xC00 → no csr_wr_en, resp_illegal=0, resp_rdata=storage value.
3. CSRRW: addr 0xC02, rs1=1 → resp_illegal=1, no write. CSRRW to 0x7C0 with CHECK_ADDR=1 → illegal. op 100 → illegal.
4. CSRRW with rd_zero: addr 0x305, 0x8000_0100 → no csr_rd_en; csr_wr_en at T+1; resp_valid at T+2 with rdata 0.
5. trap_valid and req_valid high together in IDLE → trap write (0x341, 0x0000_1234) at T+1; request accepted at T+2; resp_ready low 3 cycles → resp_valid/rdata held stable.
6. reset driven low during WAIT of a CSRRS → outputs 0 asynchronously; after release no csr_wr_en; next request completes normally.
